// File: rtl/serial_xnor_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_xnor_comparator
// Description : Compares two serial bit streams of WIDTH beats, one pair per
//               qualified beat, using the XNOR equality function. Reports a
//               one-cycle done pulse with the match count, overall equality,
//               and the index of the first differing pair.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_xnor_comparator #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          a,
  input  logic          b,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic [CW-1:0] match_count,
  output logic          mismatch_found,
  output logic [CW-1:0] first_mismatch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST_IDX = CW'(WIDTH - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_busy;
  logic          r_done;
  logic          r_equal;
  logic          r_acc;
  logic          r_mm;
  logic [CW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_first;

  logic          w_m;
  logic          w_beat;
  logic          w_last;

  // Per-beat equality bit and beat qualifiers.
  assign w_m    = ~(a ^ b);
  assign w_beat = (r_state == SHIFT) && bit_valid;
  assign w_last = w_beat && (r_idx == C_LAST_IDX);

  // Next-state decode; start is only looked at in IDLE so it cannot queue.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus registered busy/done; done trails the DONE state by
  // one edge so it rises on the edge after the final beat is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == SHIFT);
      r_done  <= (r_state == DONE);
    end
  end

  // Frame datapath: clear on accepted start, accumulate on valid beats, and
  // hold results everywhere else until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b1;
      r_mm    <= 1'b0;
      r_first <= '0;
      r_equal <= 1'b0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_idx   <= '0;
        r_cnt   <= '0;
        r_acc   <= 1'b1;
        r_mm    <= 1'b0;
        r_first <= '0;
        r_equal <= 1'b0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, w_m};
        r_acc <= r_acc & w_m;
        r_idx <= r_idx + 1'b1;
        if (!w_m && !r_mm) begin
          r_first <= r_idx;
          r_mm    <= 1'b1;
        end
        // Publishing equal with the final beat keeps equal and
        // match_count==WIDTH consistent at every cycle.
        if (w_last) r_equal <= r_acc & w_m;
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign equal          = r_equal;
  assign match_count    = r_cnt;
  assign mismatch_found = r_mm;
  assign first_mismatch = r_first;

endmodule
`default_nettype wire
